irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

Upstream request-capture stage for the 8-to-3 priority encoder in the processor's I/O path. It performs the following steps:
- synchronises eight asynchronous event lines (buttons, sensors, game timers);
- detects rising edges and holds each event as a pending bit;
- presents the highest-index pending event as a registered 3-bit code with a valid/ack handshake for the processor's interrupt/poll logic.

Priority selection uses the existing `encoder_8_bit`. This block adds the sequential capture, hold and clear behaviour that `encoder_8_bit` lacks.

## Interface
Parameters:
- NUM_SRC, 8, number of request lines; fixed at 8 to match the encoder.
- CODE_W, 3, code width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- enable  in  1  when 0, no new code is loaded onto the output; capture continues.
- req_in  in  8  asynchronous event lines; bit 7 has highest priority.
- ack  in  1  consumer accepts the presented code; meaningful only while irq_valid=1.
- irq_valid  out  1  a code is being presented.
- irq_code  out  3  index of the presented event.
- pending  out  8  current pending bits, for debug and status reads.
- missed  out  1  sticky flag: an edge arrived on a source already pending.

## Operation
Datapath:
- Two-flop synchroniser per bit: sync0 ← req_in, then sync1 ← sync0.
- prev ← sync1.
- edge = sync1 & ~prev.
- pending next = (pending & ~clr_mask) | edge.
  - clr_mask is a one-hot of irq_code when ack & irq_valid, otherwise 0.
  - If set and clear hit the same bit in one cycle, set wins: the new event is kept.
- missed sets when (edge & pending & ~clr_mask) is nonzero. It clears only on reset.

Output state machine:
- IDLE (irq_valid=0):
  - If enable=1 and pending≠0, load irq_code from the encoder output of pending, set irq_valid=1, go to PRESENT.
  - Otherwise stay in IDLE.
- PRESENT (irq_valid=1):
  - irq_code is held stable regardless of new higher-priority edges or enable changes.
  - On ack=1: clear that pending bit, irq_valid=0, go to IDLE.
- ack while in IDLE is ignored.
- The unused encoder code for pending=0 is never loaded.

Reset:
- Sync registers, prev, pending, missed, irq_valid and irq_code all reset to 0.
- State resets to IDLE.
- A reset asserted mid-handshake discards the presented code and all pending events.
- An input held high through the release of reset yields exactly one event, because prev resets to 0.

## Timing
- Capture latency: req_in first sampled high at edge k gives:
  - sync0=1 after k;
  - sync1=1 after k+1;
  - pending bit=1 after k+2;
  - irq_valid=1 after k+3, provided the block was in IDLE with enable=1.
- Handshake:
  - ack sampled at edge t clears the bit and drops irq_valid after t.
  - The next code appears after t+1, so irq_valid has at least one low cycle between codes.
  - Maximum throughput is one code per two cycles.
- A request pulse shorter than one clock period may be lost; sources must hold each request for at least 2 cycles.
- A re-trigger needs req_in low for at least 2 cycles, so that it is seen as a new edge.
- enable falling while in PRESENT does not retract the presented code.

## Structure
- Shared package holds:
  - NUM_SRC = 8 and CODE_W = 3;
  - the state encoding: IDLE = 1'b0, PRESENT = 1'b1.
- One sub-module: an instance of `encoder_8_bit`, fed by the eight pending bits; its output drives the irq_code load path.
- The synchroniser, edge detect, pending register and FSM stay in this module (target 150–250 lines).

## Test plan
- **Single event:** reset, then enable=1 and req_in=8'h04 held for 3 cycles → irq_valid=1 three edges after first sampling, with irq_code=3'd2. Ack for one cycle → pending=0 and irq_valid=0.
- **Priority order:** req_in=8'h82 rises simultaneously → codes 7 then 1, in that order, each with its own ack, and a low irq_valid cycle between them.
- **Hold stability:** while presenting code 2, raise req_in[6] → irq_code stays 2 until ack, then code 6 is presented.
- **Missed and simultaneous set/clear:**
  - Re-trigger bit 3 while it is pending and unacked → missed=1 and stays set.
  - Separately, a bit-3 edge arriving in the same cycle as its ack → pending[3] remains 1 and is re-presented.
- **enable and spurious ack:**
  - With enable=0 and req_in=8'h10 → pending=8'h10 and irq_valid stays 0.
  - Raising enable → code 4 appears on the next edge.
  - ack in IDLE → no state change.
- **Reset mid-operation:** assert reset while presenting with pending=8'hA0 → all outputs 0 on the next edge. Holding req_in[5] high through reset release → exactly one code-5 event.

Source files
------------

// File: rtl/irq_pending_latch_pkg.sv
// Shared widths, FSM state encoding and a one-hot helper for the
// interrupt pending latch and its priority encoder.
package irq_pending_latch_pkg;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned CODE_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // One-hot mask selecting the source named by a code
    function automatic logic [NUM_SRC-1:0] code_onehot(input logic [CODE_W-1:0] code);
        return NUM_SRC'(1) << code;
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/present/ack bundle between the event sources, the consumer
// and the pending latch.
interface irq_pending_latch_if;

    logic                                         enable;
    logic [irq_pending_latch_pkg::NUM_SRC-1:0]    req_in;
    logic                                         ack;
    logic                                         irq_valid;
    logic [irq_pending_latch_pkg::CODE_W-1:0]     irq_code;
    logic [irq_pending_latch_pkg::NUM_SRC-1:0]    pending;
    logic                                         missed;

    modport master (
        output enable, req_in, ack,
        input  irq_valid, irq_code, pending, missed
    );

    modport slave (
        input  enable, req_in, ack,
        output irq_valid, irq_code, pending, missed
    );

endinterface

// File: rtl/encoder_8_bit.sv
// Combinational 8-to-3 priority encoder; the highest set index wins and
// an all-zero input yields code 0.
module encoder_8_bit
    import irq_pending_latch_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    output logic [CODE_W-1:0]  o_code
);

    always_comb begin
        o_code = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (i_req[i]) begin
                o_code = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// Synchronises eight event lines, latches rising edges as pending bits and
// presents the highest-priority pending source with a valid/ack handshake.
module irq_pending_latch
    import irq_pending_latch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    irq_pending_latch_if.slave bus
);

    logic [NUM_SRC-1:0] r_sync0;
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic               r_missed;
    logic               r_irq_valid;
    logic [CODE_W-1:0]  r_irq_code;
    state_e             r_state;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_clr_mask;
    logic [CODE_W-1:0]  w_enc_code;

    assign w_edge     = r_sync1 & ~r_prev;
    assign w_clr_mask = (bus.ack && r_irq_valid) ? code_onehot(r_irq_code) : '0;

    encoder_8_bit u_encoder (
        .i_req  (r_pending),
        .o_code (w_enc_code)
    );

    // Capture path: set has priority over a same-cycle clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync0   <= '0;
            r_sync1   <= '0;
            r_prev    <= '0;
            r_pending <= '0;
            r_missed  <= 1'b0;
        end else begin
            r_sync0   <= bus.req_in;
            r_sync1   <= r_sync0;
            r_prev    <= r_sync1;
            r_pending <= (r_pending & ~w_clr_mask) | w_edge;
            if (|(w_edge & r_pending & ~w_clr_mask)) begin
                r_missed <= 1'b1;
            end
        end
    end

    // Presentation FSM: code is frozen while PRESENT until acked
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_irq_valid <= 1'b0;
            r_irq_code  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable && (|r_pending)) begin
                        r_irq_code  <= w_enc_code;
                        r_irq_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_valid = r_irq_valid;
    assign bus.irq_code  = r_irq_code;
    assign bus.pending   = r_pending;
    assign bus.missed    = r_missed;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: capture latency, priority order,
// hold stability, missed/set-wins, enable gating and reset behaviour.
module tb_irq_pending_latch;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    irq_pending_latch_if bus_if ();

    irq_pending_latch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.req_in = 8'h00;
        bus_if.ack    = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();
        check("rst_valid",   32'(bus_if.irq_valid), 32'd0);
        check("rst_code",    32'(bus_if.irq_code),  32'd0);
        check("rst_pending", 32'(bus_if.pending),   32'h00);
        check("rst_missed",  32'(bus_if.missed),    32'd0);

        // Single event: first sampled at edge k, valid after k+3
        bus_if.enable = 1'b1;
        bus_if.req_in = 8'h04;
        ticks(3);
        check("single_pend_k2",  32'(bus_if.pending),   32'h04);
        check("single_valid_k2", 32'(bus_if.irq_valid), 32'd0);
        bus_if.req_in = 8'h00;
        tick();
        check("single_valid_k3", 32'(bus_if.irq_valid), 32'd1);
        check("single_code",     32'(bus_if.irq_code),  32'd2);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check("single_ack_valid", 32'(bus_if.irq_valid), 32'd0);
        check("single_ack_pend",  32'(bus_if.pending),   32'h00);
        ticks(3);

        // Priority order 7 then 1
        bus_if.req_in = 8'h82;
        ticks(4);
        check("prio_valid0", 32'(bus_if.irq_valid), 32'd1);
        check("prio_code7",  32'(bus_if.irq_code),  32'd7);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check("prio_gap_valid", 32'(bus_if.irq_valid), 32'd0);
        check("prio_gap_pend",  32'(bus_if.pending),   32'h02);
        tick();
        check("prio_valid1", 32'(bus_if.irq_valid), 32'd1);
        check("prio_code1",  32'(bus_if.irq_code),  32'd1);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack    = 1'b0;
        bus_if.req_in = 8'h00;
        check("prio_done_pend", 32'(bus_if.pending), 32'h00);
        ticks(3);

        // Hold stability while a higher source arrives
        bus_if.req_in = 8'h04;
        ticks(4);
        check("hold_code2", 32'(bus_if.irq_code), 32'd2);
        bus_if.req_in = 8'h44;
        ticks(3);
        check("hold_pend44",  32'(bus_if.pending),   32'h44);
        check("hold_valid",   32'(bus_if.irq_valid), 32'd1);
        check("hold_code_st", 32'(bus_if.irq_code),  32'd2);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check("hold_ack_pend", 32'(bus_if.pending), 32'h40);
        tick();
        check("hold_code6",  32'(bus_if.irq_code),  32'd6);
        check("hold_valid6", 32'(bus_if.irq_valid), 32'd1);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack    = 1'b0;
        bus_if.req_in = 8'h00;
        ticks(3);
        check("hold_end_pend",   32'(bus_if.pending), 32'h00);
        check("hold_end_missed", 32'(bus_if.missed),  32'd0);

        // Re-trigger of an unacked source sets missed
        bus_if.req_in = 8'h08;
        ticks(4);
        check("miss_code3", 32'(bus_if.irq_code), 32'd3);
        bus_if.req_in = 8'h00;
        ticks(2);
        bus_if.req_in = 8'h08;
        ticks(4);
        check("miss_set",   32'(bus_if.missed),   32'd1);
        check("miss_pend",  32'(bus_if.pending),  32'h08);
        check("miss_code",  32'(bus_if.irq_code), 32'd3);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack    = 1'b0;
        bus_if.req_in = 8'h00;
        check("miss_ack_pend", 32'(bus_if.pending), 32'h00);
        check("miss_sticky",   32'(bus_if.missed),  32'd1);
        ticks(3);

        // Set and clear of bit 3 in the same cycle: set wins
        bus_if.req_in = 8'h08;
        ticks(2);
        bus_if.req_in = 8'h00;
        ticks(2);
        check("sc_valid_pre", 32'(bus_if.irq_valid), 32'd1);
        bus_if.req_in = 8'h08;
        ticks(2);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check("sc_pend_kept", 32'(bus_if.pending),   32'h08);
        check("sc_valid_low", 32'(bus_if.irq_valid), 32'd0);
        tick();
        check("sc_represent", 32'(bus_if.irq_valid), 32'd1);
        check("sc_code3",     32'(bus_if.irq_code),  32'd3);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack    = 1'b0;
        bus_if.req_in = 8'h00;
        check("sc_done_pend", 32'(bus_if.pending), 32'h00);
        ticks(3);

        // enable gating and ack while idle
        bus_if.enable = 1'b0;
        bus_if.req_in = 8'h10;
        ticks(4);
        check("en_pend",  32'(bus_if.pending),   32'h10);
        check("en_valid", 32'(bus_if.irq_valid), 32'd0);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check("idle_ack_pend",  32'(bus_if.pending),   32'h10);
        check("idle_ack_valid", 32'(bus_if.irq_valid), 32'd0);
        bus_if.enable = 1'b1;
        tick();
        check("en_rise_valid", 32'(bus_if.irq_valid), 32'd1);
        check("en_rise_code",  32'(bus_if.irq_code),  32'd4);
        bus_if.enable = 1'b0;
        tick();
        check("en_fall_hold", 32'(bus_if.irq_valid), 32'd1);
        bus_if.enable = 1'b1;
        bus_if.ack    = 1'b1;
        tick();
        bus_if.ack    = 1'b0;
        bus_if.req_in = 8'h00;
        ticks(3);

        // Reset mid-handshake, bit 5 held through release
        bus_if.req_in = 8'hA0;
        ticks(4);
        check("rm_pend",  32'(bus_if.pending),  32'hA0);
        check("rm_code7", 32'(bus_if.irq_code), 32'd7);
        reset         = 1'b1;
        bus_if.req_in = 8'h20;
        tick();
        check("rm_valid0",  32'(bus_if.irq_valid), 32'd0);
        check("rm_code0",   32'(bus_if.irq_code),  32'd0);
        check("rm_pend0",   32'(bus_if.pending),   32'h00);
        check("rm_missed0", 32'(bus_if.missed),    32'd0);
        tick();
        reset = 1'b0;
        ticks(4);
        check("rel_valid", 32'(bus_if.irq_valid), 32'd1);
        check("rel_code5", 32'(bus_if.irq_code),  32'd5);
        check("rel_pend",  32'(bus_if.pending),   32'h20);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        ticks(5);
        check("rel_once_valid",  32'(bus_if.irq_valid), 32'd0);
        check("rel_once_pend",   32'(bus_if.pending),   32'h00);
        check("rel_once_missed", 32'(bus_if.missed),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
